// File: rtl/fir_coef_loader.sv
// fir_coef_loader: buffers NTAPS coefficients written by the host and streams them gap-free,
// one per clock in index order, onto the serial cfg_din/cfg_ce load port of the FIR filter.
// Optional feature macro: COEF_LOADER_SYM_EN adds i_sym_mode for mirrored (linear-phase) loads.
module fir_coef_loader #(
  parameter int unsigned NTAPS  = 21,
  parameter int unsigned COEF_W = 25,
  parameter int unsigned AW     = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [COEF_W-1:0] i_wr_data,
  output logic              o_wr_err,
  input  logic              i_start,
`ifdef COEF_LOADER_SYM_EN
  input  logic              i_sym_mode,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [COEF_W-1:0] o_cfg_din,
  output logic              o_cfg_ce
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NTAPS - 1);

  state_e            r_state, w_state_d;
  logic [COEF_W-1:0] r_mem [NTAPS];
  logic [AW-1:0]     r_idx;
  logic [AW-1:0]     w_rd_addr;
  logic              w_wr_ok;
  logic              r_wr_err, r_busy, r_done, r_cfg_ce;
  logic [COEF_W-1:0] r_cfg_din;

  // Writes only land while idle and in range; anything else is reported via wr_err.
  assign w_wr_ok = i_wr_en && (r_state == StIdle) && (i_wr_addr <= LastIdx);

`ifdef COEF_LOADER_SYM_EN
  logic          r_sym;
  logic [AW-1:0] w_mirror;

  assign w_mirror  = LastIdx - r_idx;
  // Mirrored mode reads entry min(i, NTAPS-1-i).
  assign w_rd_addr = (r_sym && (r_idx > w_mirror)) ? w_mirror : r_idx;

  // Capture the mode together with an accepted start; it holds for the whole load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sym <= 1'b0;
    end else if (r_state == StIdle && i_start) begin
      r_sym <= i_sym_mode;
    end
  end
`else
  assign w_rd_addr = r_idx;
`endif

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_d = StRead;
      StRead:  if (r_idx == LastIdx) w_state_d = StDrain;
      StDrain: w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State, read index and registered outputs; the read register doubles as cfg_din.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_wr_err  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_ce  <= 1'b0;
      r_cfg_din <= '0;
    end else begin
      r_state  <= w_state_d;
      r_wr_err <= i_wr_en && !w_wr_ok;
      r_busy   <= (w_state_d != StIdle);
      r_done   <= (w_state_d == StDone);
      r_cfg_ce <= (r_state == StRead);
      if (r_state == StRead) begin
        r_cfg_din <= r_mem[w_rd_addr];
        r_idx     <= (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
      end else begin
        r_cfg_din <= '0;
      end
    end
  end

  // Coefficient buffer write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_wr_err  = r_wr_err;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_cfg_ce  = r_cfg_ce;
  assign o_cfg_din = r_cfg_din;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader: expected stream values are queued at start and popped
// whenever cfg_ce is observed; load timing, wr_err and reset behaviour are checked inline.
module tb_fir_coef_loader;

  localparam int unsigned NTAPS  = 21;
  localparam int unsigned COEF_W = 25;
  localparam int unsigned AW     = 5;

  logic              clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_wr_en = 1'b0;
  logic [AW-1:0]     i_wr_addr = '0;
  logic [COEF_W-1:0] i_wr_data = '0;
  logic              i_start = 1'b0;
`ifdef COEF_LOADER_SYM_EN
  logic              i_sym_mode = 1'b0;
`endif
  logic              o_wr_err, o_busy, o_done, o_cfg_ce;
  logic [COEF_W-1:0] o_cfg_din;

  int unsigned       n_checks = 0;
  int unsigned       n_errors = 0;
  int unsigned       done_cnt = 0;
  logic [COEF_W-1:0] mdl [NTAPS];
  logic [COEF_W-1:0] exp_q [$];

  fir_coef_loader #(.NTAPS(NTAPS), .COEF_W(COEF_W), .AW(AW)) u_dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .o_wr_err  (o_wr_err),
    .i_start   (i_start),
`ifdef COEF_LOADER_SYM_EN
    .i_sym_mode(i_sym_mode),
`endif
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_cfg_din (o_cfg_din),
    .o_cfg_ce  (o_cfg_ce)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every cfg_ce beat must match the next queued coefficient; idle din must be 0.
  always @(negedge clk) begin
    if (i_reset_n) begin
      if (o_done) done_cnt++;
      if (o_cfg_ce) begin
        if (exp_q.size() == 0) check("extra_ce", {31'd0, o_cfg_ce}, 32'd0);
        else check("cfg_din", 32'(o_cfg_din), 32'(exp_q.pop_front()));
      end else begin
        check("din_idle_zero", 32'(o_cfg_din), 32'd0);
      end
    end
  end

  // Single write while idle; wr_err is expected exactly when the address is out of range.
  task automatic wr(input int unsigned addr, input logic [COEF_W-1:0] data);
    @(negedge clk);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(addr);
    i_wr_data = data;
    @(negedge clk);
    i_wr_en = 1'b0;
    check("wr_err_idle", {31'd0, o_wr_err}, {31'd0, addr >= NTAPS});
    if (addr < NTAPS) mdl[addr] = data;
  endtask

  function automatic int unsigned src_idx(input bit sym, input int unsigned i);
    if (sym && (i > NTAPS - 1 - i)) return NTAPS - 1 - i;
    return i;
  endfunction

  // Full load: optional same-cycle write to entry 0, optional write+start while busy.
  task automatic run_load(input bit sym, input bit combo, input logic [COEF_W-1:0] cdata,
                          input bit disturb);
    int unsigned n_ce = 0, first_k = 0, done_k = 0, n_err = 0;
    int unsigned done_base;
    @(negedge clk);
    if (combo) begin
      i_wr_en   = 1'b1;
      i_wr_addr = '0;
      i_wr_data = cdata;
      mdl[0]    = cdata;
    end
    i_start = 1'b1;
`ifdef COEF_LOADER_SYM_EN
    i_sym_mode = sym;
`endif
    for (int unsigned i = 0; i < NTAPS; i++) exp_q.push_back(mdl[src_idx(sym, i)]);
    done_base = done_cnt;
    for (int unsigned k = 1; k <= NTAPS + 8 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_start = 1'b0;
        i_wr_en = 1'b0;
        check("busy_first", {31'd0, o_busy}, 32'd1);
        check("ce_first_low", {31'd0, o_cfg_ce}, 32'd0);
      end
      if (o_cfg_ce) begin
        if (n_ce == 0) first_k = k;
        n_ce++;
      end
      if (o_wr_err) n_err++;
      if (o_done) done_k = k;
      else check("busy_during", {31'd0, o_busy}, 32'd1);
      if (disturb && k == 5) begin
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(3);
        i_wr_data = 25'h1FF_FFFF;
        i_start   = 1'b1;
      end else if (disturb && k == 6) begin
        i_wr_en = 1'b0;
        i_start = 1'b0;
      end
    end
    check("first_ce_cycle", first_k, 32'd2);
    check("ce_count", n_ce, NTAPS);
    check("done_cycle", done_k, NTAPS + 2);
    check("wr_err_busy", n_err, {31'd0, disturb});
    @(negedge clk);
    check("busy_after", {31'd0, o_busy}, 32'd0);
    check("done_single", done_cnt - done_base, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  // Reset asserted at the 10th cfg_ce beat must kill the load with no done.
  task automatic reset_mid_load();
    int unsigned n_ce = 0;
    int unsigned done_base;
    @(negedge clk);
    i_start = 1'b1;
    for (int unsigned i = 0; i < NTAPS; i++) exp_q.push_back(mdl[i]);
    done_base = done_cnt;
    for (int unsigned k = 1; k <= NTAPS + 8 && n_ce < 10; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_cfg_ce) n_ce++;
    end
    check("reached_ce10", n_ce, 32'd10);
    i_reset_n = 1'b0;
    #1;
    check("rst_ce", {31'd0, o_cfg_ce}, 32'd0);
    check("rst_din", 32'(o_cfg_din), 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_done", done_cnt - done_base, 32'd0);
    check("rst_idle_busy", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_ce", {31'd0, o_cfg_ce}, 32'd0);
    check("reset_err", {31'd0, o_wr_err}, 32'd0);
    i_reset_n = 1'b1;

    // Ramp 1..21.
    for (int unsigned k = 0; k < NTAPS; k++) wr(k, COEF_W'(k + 1));
    run_load(1'b0, 1'b0, '0, 1'b0);

    // Unit tap at index 8.
    for (int unsigned k = 0; k < NTAPS; k++) wr(k, (k == 8) ? 25'h0_8_0000 : '0);
    run_load(1'b0, 1'b0, '0, 1'b0);

    // Write and start while busy: rejected, stream and buffer unaffected.
    wr(3, 25'h0_0_1234);
    run_load(1'b0, 1'b0, '0, 1'b1);
    run_load(1'b0, 1'b0, '0, 1'b0);

    // Reset mid-load, then a clean full load.
    reset_mid_load();
    run_load(1'b0, 1'b0, '0, 1'b0);

    // Out-of-range write, then write+start in the same cycle.
    wr(21, 25'h0AB_CDEF);
    run_load(1'b0, 1'b1, 25'h100_0000, 1'b0);

`ifdef COEF_LOADER_SYM_EN
    for (int unsigned k = 0; k < NTAPS; k++) wr(k, (k <= 10) ? COEF_W'(k + 10) : '0);
    run_load(1'b1, 1'b0, '0, 1'b0);
    run_load(1'b0, 1'b0, '0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
